// File: rtl/fifo_ctrl_axil_slave_if.sv
// rtl/fifo_ctrl_axil_slave_if.sv - AXI4-Lite bus bundle for the FIFO controller slave
interface fifo_ctrl_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/fifo_ctrl_axil_slave.sv
// rtl/fifo_ctrl_axil_slave.sv - AXI4-Lite slave wrapping a word FIFO with status, control and scratch registers
module fifo_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  fifo_ctrl_axil_slave_if.slave  s_axi,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]                 wptr, rptr;
  logic [PW:0]                   count;
  logic [8:0]                    count9;
  logic                          ovf_sticky, udf_sticky;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch;
  logic                          awready_q, arready_q, bvalid_q, rvalid_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rd_mux;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [1:0]                    wsel, rsel;
  logic                          aw_hs, ar_hs, push, pop, do_flush, do_clr, wr_ovf, rd_udf;
  logic                          unused_bits;

  assign awaddr = s_axi.S_AXI_AWADDR;
  assign araddr = s_axi.S_AXI_ARADDR;
  assign wsel   = awaddr[3:2];
  assign rsel   = araddr[3:2];
  assign unused_bits = ^{awaddr[1:0], araddr[1:0], s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

  assign count9     = 9'(count);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign irq        = ovf_sticky | udf_sticky;

  // The ready registers mark the handshake cycle; all register side effects happen there.
  assign aw_hs    = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign ar_hs    = arready_q & s_axi.S_AXI_ARVALID;
  assign do_flush = aw_hs && (wsel == REG_CTRL) && s_axi.S_AXI_WDATA[0];
  assign do_clr   = aw_hs && (wsel == REG_CTRL) && s_axi.S_AXI_WDATA[1];
  assign wr_ovf   = aw_hs && (wsel == REG_DATA) && fifo_full;
  assign rd_udf   = ar_hs && (rsel == REG_DATA) && fifo_empty;
  assign push     = aw_hs && (wsel == REG_DATA) && !fifo_full;
  assign pop      = ar_hs && (rsel == REG_DATA) && !fifo_empty;

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  always_comb begin
    rd_mux = '0;
    case (rsel)
      REG_DATA:    rd_mux = fifo_empty ? '0 : mem[rptr];
      REG_STATUS: begin
        rd_mux[8:0] = count9;
        rd_mux[16]  = fifo_empty;
        rd_mux[17]  = fifo_full;
        rd_mux[24]  = ovf_sticky;
        rd_mux[25]  = udf_sticky;
      end
      REG_SCRATCH: rd_mux = scratch;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_q && !awready_q;
      if (aw_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ovf ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= s_axi.S_AXI_ARVALID && !rvalid_q && !arready_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
        rresp_q  <= rd_udf ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Flush wins over any DATA push/pop landing in the same cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
      scratch    <= '0;
    end else begin
      if (do_flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
        if (push && !pop)      count <= count + (PW+1)'(1);
        else if (pop && !push) count <= count - (PW+1)'(1);
      end
      if (wr_ovf)      ovf_sticky <= 1'b1;
      else if (do_clr) ovf_sticky <= 1'b0;
      if (rd_udf)      udf_sticky <= 1'b1;
      else if (do_clr) udf_sticky <= 1'b0;
      if (aw_hs && (wsel == REG_SCRATCH)) begin
        for (int i = 0; i < C_S_AXI_DATA_WIDTH/8; i++) begin
          if (s_axi.S_AXI_WSTRB[i]) scratch[8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) mem[wptr] <= s_axi.S_AXI_WDATA;
  end
endmodule
